data_format_in: RTL and testbench

//  Write-side width up-converter (gearbox) for the DDR2 datapath: packs DIV narrow user words into one wide word.

---
 rtl/data_format_in_pkg.sv | 32 +++
 rtl/data_format_in_buf.sv | 81 ++++++++
 rtl/data_format_in.sv | 105 ++++++++++
 tb/tb_data_format_in.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_format_in_pkg.sv
// data_format_in_pkg
//   Shared definitions for the write-side width up-converter:
//   lane-count derivation, counter width, clog2 helper and the
//   occupancy encoding of the 2-entry output buffer.
package data_format_in_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic int clog2(input int unsigned value);
        int res;
        res = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Number of narrow lanes packed into one wide word.
    function automatic int div_of(input int do_width, input int di_width);
        return do_width / di_width;
    endfunction

    // Lane counter width, never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (clog2(div) < 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/data_format_in_buf.sv
// data_format_in_buf
//   2-entry valid/ready FIFO holding closed wide words. The head entry is a
//   register that drives the output directly, so it stays stable on stall.
// Ports
//   clk, reset    : clock, asynchronous active-high reset
//   i_push/i_data : write side; caller pushes only when o_can_push
//   o_can_push    : room for a push this cycle (includes same-edge pop)
//   o_data/o_vd   : head entry and its valid flag
//   i_rdy         : downstream ready, pop when o_vd & i_rdy
module data_format_in_buf
    import data_format_in_pkg::*;
#(
    parameter int W = 67
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_can_push,
    output logic [W-1:0] o_data,
    output logic         o_vd,
    input  logic         i_rdy
);

    buf_state_t   r_state;
    buf_state_t   w_next;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_pop      = (r_state != BUF_EMPTY) && i_rdy;
        w_next     = r_state;
        o_vd       = (r_state != BUF_EMPTY);
        o_can_push = (r_state != BUF_TWO) || w_pop;
        case (r_state)
            BUF_EMPTY: if (i_push) w_next = BUF_ONE;
            BUF_ONE: begin
                if (i_push && !w_pop)      w_next = BUF_TWO;
                else if (!i_push && w_pop) w_next = BUF_EMPTY;
            end
            BUF_TWO:   if (w_pop && !i_push) w_next = BUF_ONE;
            default:   w_next = BUF_EMPTY;
        endcase
    end

    // Push into ONE with a pop goes straight to the head; in TWO the tail
    // shifts forward and the new word takes its place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: if (i_push) r_head <= i_data;
                BUF_ONE: begin
                    if (i_push && w_pop) r_head <= i_data;
                    else if (i_push)     r_tail <= i_data;
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data = r_head;

endmodule

// File: rtl/data_format_in.sv
// data_format_in
//   Write-side width up-converter: packs DIV narrow words into one wide word,
//   flushing early on din_last with a per-lane keep mask. Closed words pass
//   through a 2-entry buffer to a valid/ready output stream.
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   data_in/din_vd     : narrow input word and valid
//   din_last           : last word of burst, closes a partial wide word
//   din_rdy            : input accepted when din_vd & din_rdy
//   data_out/dout_keep : packed wide word and lane-valid mask
//   dout_last          : wide word was closed by din_last
//   dout_vd/dout_rdy   : output handshake
module data_format_in
    import data_format_in_pkg::*;
#(
    parameter int DI_WIDTH  = 32,
    parameter int DO_WIDTH  = 64,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [DI_WIDTH-1:0]                     data_in,
    input  logic                                    din_vd,
    input  logic                                    din_last,
    output logic                                    din_rdy,
    output logic [DO_WIDTH-1:0]                     data_out,
    output logic [div_of(DO_WIDTH, DI_WIDTH)-1:0]   dout_keep,
    output logic                                    dout_last,
    output logic                                    dout_vd,
    input  logic                                    dout_rdy
);

    localparam int DIV   = div_of(DO_WIDTH, DI_WIDTH);
    localparam int CNT_W = cnt_width(DIV);
    localparam int BW    = DO_WIDTH + DIV + 1;

    logic                r_run;
    logic [CNT_W-1:0]    r_cnt;
    logic [DO_WIDTH-1:0] r_acc;
    logic [DIV-1:0]      r_keep;

    logic [CNT_W-1:0]    w_lane;
    logic [DO_WIDTH-1:0] w_acc_nxt;
    logic [DIV-1:0]      w_keep_nxt;
    logic                w_beat;
    logic                w_close;
    logic                w_can_push;
    logic [BW-1:0]       w_buf_q;

    // Held low through reset and until the first edge after release.
    assign din_rdy = r_run && w_can_push;
    assign w_beat  = din_vd && din_rdy;
    assign w_close = (r_cnt == CNT_W'(DIV - 1)) || din_last;
    assign w_lane  = LSB_FIRST ? r_cnt : (CNT_W'(DIV - 1) - r_cnt);

    // Accumulator with the incoming word merged into its lane.
    always_comb begin
        w_acc_nxt  = r_acc;
        w_keep_nxt = r_keep;
        for (int unsigned i = 0; i < DIV; i++) begin
            if (CNT_W'(i) == w_lane) begin
                w_acc_nxt[i*DI_WIDTH +: DI_WIDTH] = data_in;
                w_keep_nxt[i]                     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_keep <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_beat) begin
                if (w_close) begin
                    r_cnt  <= '0;
                    r_acc  <= '0;
                    r_keep <= '0;
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_acc  <= w_acc_nxt;
                    r_keep <= w_keep_nxt;
                end
            end
        end
    end

    data_format_in_buf #(
        .W(BW)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_beat && w_close),
        .i_data     ({w_acc_nxt, w_keep_nxt, din_last}),
        .o_can_push (w_can_push),
        .o_data     (w_buf_q),
        .o_vd       (dout_vd),
        .i_rdy      (dout_rdy)
    );

    assign {data_out, dout_keep, dout_last} = w_buf_q;

endmodule

// File: tb/tb_data_format_in.sv
module tb_data_format_in;

    localparam int DI  = 32;
    localparam int DO  = 64;
    localparam int DIV = DO / DI;

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic [DI-1:0] data_in = '0;
    logic          din_vd = 1'b0, din_last = 1'b0, din_rdy;
    logic [DO-1:0] data_out;
    logic [DIV-1:0] dout_keep;
    logic          dout_last, dout_vd;
    logic          dout_rdy = 1'b1;

    logic [DI-1:0] data_in_b = '0;
    logic          din_vd_b = 1'b0, din_last_b = 1'b0, din_rdy_b;
    logic [DO-1:0] data_out_b;
    logic [DIV-1:0] dout_keep_b;
    logic          dout_last_b, dout_vd_b;
    logic          dout_rdy_b = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    typedef struct {
        logic [DO-1:0]  d;
        logic [DIV-1:0] k;
        logic           l;
    } exp_t;

    exp_t          q[$];
    logic [DO-1:0] m_acc  = '0;
    logic [DIV-1:0] m_keep = '0;
    int            m_n    = 0;
    bit            m_run  = 0;
    bit            prev_stall = 0;
    logic [DO-1:0] prev_data;
    logic [DIV-1:0] prev_keep;
    bit            done6 = 0;

    data_format_in #(.DI_WIDTH(DI), .DO_WIDTH(DO), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .din_vd(din_vd),
        .din_last(din_last), .din_rdy(din_rdy), .data_out(data_out),
        .dout_keep(dout_keep), .dout_last(dout_last), .dout_vd(dout_vd),
        .dout_rdy(dout_rdy)
    );

    data_format_in #(.DI_WIDTH(DI), .DO_WIDTH(DO), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in_b), .din_vd(din_vd_b),
        .din_last(din_last_b), .din_rdy(din_rdy_b), .data_out(data_out_b),
        .dout_keep(dout_keep_b), .dout_last(dout_last_b), .dout_vd(dout_vd_b),
        .dout_rdy(dout_rdy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DO-1:0] act, input logic [DO-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: expected stream of wide words derived from accepted beats.
    // Inputs only change at posedge+1, so everything seen at negedge is what
    // the next rising edge will act on.
    always @(negedge clk) begin
        bit beat, pop, exp_rdy;
        int lane;
        exp_t e;
        if (reset) begin
            chk("rst_dout_vd", DO'(dout_vd), '0);
            chk("rst_data_out", data_out, '0);
            chk("rst_din_rdy", DO'(din_rdy), '0);
            q.delete();
            m_acc = '0; m_keep = '0; m_n = 0; m_run = 0; prev_stall = 0;
        end else begin
            exp_rdy = m_run && (q.size() < 2 || (dout_rdy && q.size() != 0));
            chk("din_rdy", DO'(din_rdy), DO'(exp_rdy));
            chk("dout_vd", DO'(dout_vd), DO'(q.size() != 0));
            if (q.size() != 0) begin
                chk("data_out", data_out, q[0].d);
                chk("dout_keep", DO'(dout_keep), DO'(q[0].k));
                chk("dout_last", DO'(dout_last), DO'(q[0].l));
            end
            if (prev_stall) begin
                chk("stall_data", data_out, prev_data);
                chk("stall_keep", DO'(dout_keep), DO'(prev_keep));
            end
            prev_stall = dout_vd && !dout_rdy;
            prev_data  = data_out;
            prev_keep  = dout_keep;
            beat = din_vd && exp_rdy;
            pop  = dout_rdy && q.size() != 0;
            if (pop) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (beat) begin
                lane   = m_n;
                m_acc  = m_acc | (DO'(data_in) << (lane * DI));
                m_keep = m_keep | DIV'(1 << lane);
                m_n++;
                if (m_n == DIV || din_last) begin
                    e.d = m_acc; e.k = m_keep; e.l = din_last;
                    q.push_back(e);
                    m_acc = '0; m_keep = '0; m_n = 0;
                end
            end
            m_run = 1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [DI-1:0] w, input logic l);
        bit acc;
        int n;
        acc = 0; n = 0;
        din_vd = 1'b1; data_in = w; din_last = l;
        while (!acc) begin
            @(negedge clk);
            acc = din_rdy;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 300) begin
                checks++; errors++;
                $display("FAIL send_timeout: word %h never accepted", w);
                acc = 1;
            end
        end
        din_vd = 1'b0; din_last = 1'b0; data_in = DI'($urandom);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("async_vd", DO'(dout_vd), '0);
        chk("async_data", data_out, '0);
        chk("async_keep", DO'(dout_keep), '0);
        chk("async_last", DO'(dout_last), '0);
        chk("async_rdy", DO'(din_rdy), '0);
        chk("async_b_data", data_out_b, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        int x0;
        #1;
        chk("init_data", data_out, '0);
        chk("init_vd", DO'(dout_vd), '0);
        chk("init_keep", DO'(dout_keep), '0);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // 1: two words back-to-back
        dout_rdy = 1'b1;
        x0 = n_xfer;
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        chk("t1_vd", DO'(dout_vd), 64'd1);
        chk("t1_data", data_out, 64'h22222222_11111111);
        chk("t1_keep", DO'(dout_keep), 64'd3);
        chk("t1_last", DO'(dout_last), 64'd0);
        cyc(3);
        chk("t1_count", DO'(n_xfer - x0), 64'd1);

        // 2: eight continuous words
        x0 = n_xfer;
        for (int i = 0; i < 8; i++) send(32'hC0DE0000 + DI'(i), 1'b0);
        cyc(3);
        chk("t2_count", DO'(n_xfer - x0), 64'd4);

        // 4: single word with last, both lane orders
        din_vd_b = 1'b1; data_in_b = 32'hAAAA5555; din_last_b = 1'b1;
        send(32'hAAAA5555, 1'b1);
        din_vd_b = 1'b0; din_last_b = 1'b0;
        chk("t4_data", data_out, 64'h00000000_AAAA5555);
        chk("t4_keep", DO'(dout_keep), 64'd1);
        chk("t4_last", DO'(dout_last), 64'd1);
        chk("t4b_vd", DO'(dout_vd_b), 64'd1);
        chk("t4b_data", data_out_b, 64'hAAAA5555_00000000);
        chk("t4b_keep", DO'(dout_keep_b), 64'd2);
        chk("t4b_last", DO'(dout_last_b), 64'd1);
        cyc(2);

        // 3: stall with six words, then drain
        dout_rdy = 1'b0;
        x0 = n_xfer;
        fork
            for (int i = 0; i < 6; i++) send(32'h10000000 + DI'(i), 1'b0);
            begin
                cyc(20);
                chk("t3_rdy_low", DO'(din_rdy), 64'd0);
                chk("t3_head", data_out, 64'h10000001_10000000);
                dout_rdy = 1'b1;
            end
        join
        cyc(4);
        chk("t3_count", DO'(n_xfer - x0), 64'd3);

        // 5: reset after one lane, then with one buffered word
        send(32'hDEADBEEF, 1'b0);
        do_reset();
        send(32'h00000005, 1'b0);
        send(32'h00000006, 1'b0);
        chk("t5_fresh1", data_out, 64'h00000006_00000005);
        chk("t5_keep1", DO'(dout_keep), 64'd3);
        cyc(2);
        dout_rdy = 1'b0;
        send(32'hBAD00001, 1'b0);
        send(32'hBAD00002, 1'b0);
        cyc(1);
        do_reset();
        dout_rdy = 1'b1;
        send(32'h00000007, 1'b0);
        send(32'h00000008, 1'b0);
        chk("t5_fresh2", data_out, 64'h00000008_00000007);
        cyc(2);

        // 6: random ready, random last, 1000 words
        fork
            begin
                while (!done6) begin
                    @(posedge clk); #1;
                    dout_rdy = ($urandom_range(0, 1) == 1);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(DI'($urandom), ($urandom_range(0, 7) == 0));
                    if ($urandom_range(0, 3) == 0) cyc(1);
                end
                done6 = 1;
            end
        join
        dout_rdy = 1'b1;
        send(32'h0F0F0F0F, 1'b1);
        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 20) begin cyc(1); n++; end
        end
        cyc(1);
        chk("t6_drained", DO'(q.size()), 64'd0);
        chk("t6_vd_idle", DO'(dout_vd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
